// File: rtl/fdau_frame_sched.sv
// fdau_frame_sched: round-robin write scheduler feeding the ping-pong FDAU frame RAM.
// Define FDAU_SCHED_CKSUM_EN to append a 16-bit sum word after each frame's data.
module fdau_frame_sched #(
   parameter int unsigned FRAME_LEN = 200
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sec,
   input  logic [3:0]  req,
   input  logic [63:0] din,
   output logic [3:0]  gnt,
   output logic        ram_wren,
   output logic [8:0]  ram_wraddress,
   output logic [15:0] ram_data,
   output logic        wr_bank,
   output logic        rd_bank,
   output logic        frame_done,
   output logic        overrun,
   output logic        busy
);

   localparam logic [7:0] LEN = 8'(FRAME_LEN);

`ifdef FDAU_SCHED_CKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_WRITE,
      S_CKSUM,
      S_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_WRITE,
      S_DONE
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [3:0]  gnt_q, gnt_d;
   logic        wren_q, wren_d;
   logic [8:0]  addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        wrb_q, wrb_d;
   logic        rdb_q, rdb_d;
   logic        done_q, done_d;
   logic        ovr_q, ovr_d;
   logic        busy_q, busy_d;
`ifdef FDAU_SCHED_CKSUM_EN
   logic [15:0] sum_q, sum_d;
`endif

   logic [3:0]  rot_req;
   logic [1:0]  pick_off;
   logic [1:0]  pick_idx;
   logic        pick_vld;
   logic [15:0] pick_data;
   logic [7:0]  cnt_inc;

   // Round-robin pick: rotate requests so the search starts at the pointer.
   always_comb begin
      rot_req  = 4'({req, req} >> ptr_q);
      pick_vld = |req;
      if (rot_req[0]) begin
         pick_off = 2'd0;
      end else if (rot_req[1]) begin
         pick_off = 2'd1;
      end else if (rot_req[2]) begin
         pick_off = 2'd2;
      end else begin
         pick_off = 2'd3;
      end
      pick_idx  = ptr_q + pick_off;
      pick_data = din[{pick_idx, 4'b0000} +: 16];
   end

   // Frame sequencing; every output is computed one cycle ahead and registered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt_d   = 4'b0000;
      wren_d  = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      wrb_d   = wrb_q;
      rdb_d   = rdb_q;
      done_d  = 1'b0;
      ovr_d   = 1'b0;
      cnt_inc = cnt_q + 8'd1;
`ifdef FDAU_SCHED_CKSUM_EN
      sum_d   = sum_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (sec) begin
               state_d = S_ARB;
               cnt_d   = 8'd0;
`ifdef FDAU_SCHED_CKSUM_EN
               sum_d   = 16'd0;
`endif
            end
         end
         S_ARB: begin
            if (sec) begin
               ovr_d = 1'b1;
               cnt_d = 8'd0;
`ifdef FDAU_SCHED_CKSUM_EN
               sum_d = 16'd0;
`endif
            end else if (pick_vld) begin
               state_d = S_WRITE;
               gnt_d   = 4'b0001 << pick_idx;
               wren_d  = 1'b1;
               addr_d  = {wrb_q, cnt_q};
               data_d  = pick_data;
               ptr_d   = pick_idx + 2'd1;
            end
         end
         S_WRITE: begin
            if (sec) begin
               // The write on the bus this cycle still lands; the frame restarts.
               state_d = S_ARB;
               ovr_d   = 1'b1;
               cnt_d   = 8'd0;
`ifdef FDAU_SCHED_CKSUM_EN
               sum_d   = 16'd0;
`endif
            end else begin
               cnt_d = cnt_inc;
`ifdef FDAU_SCHED_CKSUM_EN
               sum_d = sum_q + data_q;
`endif
               if (cnt_inc == LEN) begin
`ifdef FDAU_SCHED_CKSUM_EN
                  state_d = S_CKSUM;
                  wren_d  = 1'b1;
                  addr_d  = {wrb_q, LEN};
                  data_d  = sum_q + data_q;
`else
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  wrb_d   = ~wrb_q;
                  rdb_d   = ~rdb_q;
`endif
               end else begin
                  state_d = S_ARB;
               end
            end
         end
`ifdef FDAU_SCHED_CKSUM_EN
         S_CKSUM: begin
            if (sec) begin
               state_d = S_ARB;
               ovr_d   = 1'b1;
               cnt_d   = 8'd0;
               sum_d   = 16'd0;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
               wrb_d   = ~wrb_q;
               rdb_d   = ~rdb_q;
            end
         end
`endif
         S_DONE: begin
            if (sec) begin
               state_d = S_ARB;
               cnt_d   = 8'd0;
`ifdef FDAU_SCHED_CKSUM_EN
               sum_d   = 16'd0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         ptr_q   <= 2'd0;
         gnt_q   <= 4'b0000;
         wren_q  <= 1'b0;
         addr_q  <= 9'd0;
         data_q  <= 16'd0;
         wrb_q   <= 1'b0;
         rdb_q   <= 1'b1;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef FDAU_SCHED_CKSUM_EN
         sum_q   <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wrb_q   <= wrb_d;
         rdb_q   <= rdb_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
`ifdef FDAU_SCHED_CKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign gnt           = gnt_q;
   assign ram_wren      = wren_q;
   assign ram_wraddress = addr_q;
   assign ram_data      = data_q;
   assign wr_bank       = wrb_q;
   assign rd_bank       = rdb_q;
   assign frame_done    = done_q;
   assign overrun       = ovr_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_fdau_frame_sched.sv
// tb_fdau_frame_sched: vector table, directed corner cases and a randomized
// scoreboard for the FDAU frame write scheduler (FRAME_LEN = 4).
module tb_fdau_frame_sched;

   localparam int FL = 4;

   logic        clock;
   logic        reset;
   logic        sec;
   logic [3:0]  req;
   logic [63:0] din;
   logic [3:0]  gnt;
   logic        ram_wren;
   logic [8:0]  ram_wraddress;
   logic [15:0] ram_data;
   logic        wr_bank;
   logic        rd_bank;
   logic        frame_done;
   logic        overrun;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   fdau_frame_sched #(.FRAME_LEN(FL)) dut (
      .clock         (clock),
      .reset         (reset),
      .sec           (sec),
      .req           (req),
      .din           (din),
      .gnt           (gnt),
      .ram_wren      (ram_wren),
      .ram_wraddress (ram_wraddress),
      .ram_data      (ram_data),
      .wr_bank       (wr_bank),
      .rd_bank       (rd_bank),
      .frame_done    (frame_done),
      .overrun       (overrun),
      .busy          (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        sec;
      logic [3:0]  req;
      logic [15:0] d0;
      logic [3:0]  gnt;
      logic        wren;
      logic [8:0]  addr;
      logic [15:0] data;
      logic        done;
      logic        wrb;
      logic        busy;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_wren"}, ram_wren, 0);
      chk({tag, "_addr"}, ram_wraddress, 0);
      chk({tag, "_data"}, ram_data, 0);
      chk({tag, "_wrb"}, wr_bank, 0);
      chk({tag, "_rdb"}, rd_bank, 1);
      chk({tag, "_done"}, frame_done, 0);
      chk({tag, "_ovr"}, overrun, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sec   = 1'b0;
      req   = 4'b0;
      din   = 64'h0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic pulse_sec();
      sec = 1'b1;
      @(negedge clock);
      sec = 1'b0;
   endtask

   task automatic wait_gnt(input int maxc, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < maxc && !ok; c++) begin
         @(negedge clock);
         if (gnt != 4'b0) ok = 1'b1;
      end
      chk("gnt_arrived", {31'b0, ok}, 1);
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return 4;
   endfunction

`ifdef FDAU_SCHED_CKSUM_EN
   task automatic cks_frame(input logic [15:0] d [4], input logic bank,
                            input logic [15:0] exp_sum);
      bit ok;
      req = 4'b0010;
      din = {32'h0, d[0], 16'h0};
      pulse_sec();
      for (int n = 0; n < 4; n++) begin
         wait_gnt(6, ok);
         chk("t4_data", ram_data, d[n]);
         if (n < 3) din[31:16] = d[n+1];
      end
      req = 4'b0;
      @(negedge clock);
      chk("t4_cks_wren", ram_wren, 1);
      chk("t4_cks_gnt", gnt, 0);
      chk("t4_cks_addr", ram_wraddress, {bank, 8'h04});
      chk("t4_cks_data", ram_data, exp_sum);
      @(negedge clock);
      chk("t4_done", frame_done, 1);
      @(negedge clock);
   endtask
`endif

   // randomized-phase model state
   logic [15:0] dv [4];
   logic [15:0] sum_m;
   logic [3:0]  nreq;
   logic [3:0]  eg;
   logic        bank_m;
   int          ptr_m, cnt_m, stall, ei;
   bit          in_frame, busy_exp, done_exp, cks_exp;

   initial begin
      bit ok;
`ifdef FDAU_SCHED_CKSUM_EN
      logic [15:0] da [4];
`endif
      reset = 1'b1;
      sec   = 1'b0;
      req   = 4'b0;
      din   = 64'h0;
      repeat (3) @(negedge clock);
      chk_rst("rst");
      reset = 1'b0;

      // single requester, one full frame into bank 0
      tv.push_back('{1, 4'h1, 16'h1000, 4'h0, 0, 9'h000, 16'h0000, 0, 0, 1});
      tv.push_back('{0, 4'h1, 16'h1000, 4'h1, 1, 9'h000, 16'h1000, 0, 0, 1});
      tv.push_back('{0, 4'h1, 16'h1001, 4'h0, 0, 9'h000, 16'h0000, 0, 0, 1});
      tv.push_back('{0, 4'h1, 16'h1001, 4'h1, 1, 9'h001, 16'h1001, 0, 0, 1});
      tv.push_back('{0, 4'h1, 16'h1002, 4'h0, 0, 9'h000, 16'h0000, 0, 0, 1});
      tv.push_back('{0, 4'h1, 16'h1002, 4'h1, 1, 9'h002, 16'h1002, 0, 0, 1});
      tv.push_back('{0, 4'h1, 16'h1003, 4'h0, 0, 9'h000, 16'h0000, 0, 0, 1});
      tv.push_back('{0, 4'h1, 16'h1003, 4'h1, 1, 9'h003, 16'h1003, 0, 0, 1});
`ifdef FDAU_SCHED_CKSUM_EN
      tv.push_back('{0, 4'h1, 16'h1003, 4'h0, 1, 9'h004, 16'h4006, 0, 0, 1});
`endif
      tv.push_back('{0, 4'h1, 16'h1003, 4'h0, 0, 9'h000, 16'h0000, 1, 1, 1});
      tv.push_back('{0, 4'h1, 16'h1003, 4'h0, 0, 9'h000, 16'h0000, 0, 1, 0});
      tv.push_back('{0, 4'h1, 16'h1003, 4'h0, 0, 9'h000, 16'h0000, 0, 1, 0});

      foreach (tv[k]) begin
         sec = tv[k].sec;
         req = tv[k].req;
         din = {48'h0, tv[k].d0};
         @(negedge clock);
         chk($sformatf("t1_%0d_gnt", k), gnt, tv[k].gnt);
         chk($sformatf("t1_%0d_wren", k), ram_wren, tv[k].wren);
         if (tv[k].wren) begin
            chk($sformatf("t1_%0d_addr", k), ram_wraddress, tv[k].addr);
            chk($sformatf("t1_%0d_data", k), ram_data, tv[k].data);
         end
         chk($sformatf("t1_%0d_done", k), frame_done, tv[k].done);
         chk($sformatf("t1_%0d_wrb", k), wr_bank, tv[k].wrb);
         chk($sformatf("t1_%0d_rdb", k), rd_bank, !tv[k].wrb);
         chk($sformatf("t1_%0d_busy", k), busy, tv[k].busy);
         chk($sformatf("t1_%0d_ovr", k), overrun, 0);
      end
      sec = 1'b0;
      req = 4'b0;

      // RR pointer carries across frames, then reset in the middle of a write
      req = 4'hF;
      din = {16'hD3, 16'hD2, 16'hD1, 16'hD0};
      pulse_sec();
      wait_gnt(6, ok);
      chk("t5_rr_carry", gnt, 4'b0010);
      chk("t5_addr_bank1", ram_wraddress, 9'h100);
      reset = 1'b1;
      @(negedge clock);
      chk_rst("t5_rst");
      reset = 1'b0;
      repeat (6) begin
         @(negedge clock);
         chk("t5_idle_gnt", gnt, 0);
         chk("t5_idle_busy", busy, 0);
      end
      pulse_sec();
      wait_gnt(6, ok);
      chk("t5_ptr_reset", gnt, 4'b0001);
      chk("t5_addr0", ram_wraddress, 9'h000);
      chk("t5_data0", ram_data, 16'hD0);

      // sec during a WRITE aborts the frame
      do_reset();
      req = 4'b0100;
      din = {16'h0, 16'h2000, 32'h0};
      pulse_sec();
      wait_gnt(6, ok);
      chk("t3_addr_a", ram_wraddress, 9'h000);
      din[47:32] = 16'h2001;
      wait_gnt(6, ok);
      chk("t3_addr_b", ram_wraddress, 9'h001);
      chk("t3_data_b", ram_data, 16'h2001);
      din[47:32] = 16'h2002;
      pulse_sec();
      chk("t3_overrun", overrun, 1);
      chk("t3_no_done", frame_done, 0);
      chk("t3_busy", busy, 1);
      chk("t3_bank_kept", wr_bank, 0);
      for (int n = 0; n < 4; n++) begin
         wait_gnt(6, ok);
         chk("t3_gnt", gnt, 4'b0100);
         chk("t3_addr", ram_wraddress, 9'(n));
         chk("t3_data", ram_data, 16'h2002 + 16'(n));
         chk("t3_ovr_pulse", overrun, 0);
         din[47:32] = 16'h2003 + 16'(n);
      end
      req = 4'b0;
      ok = 1'b0;
      for (int c = 0; c < 6 && !ok; c++) begin
         @(negedge clock);
         if (frame_done) ok = 1'b1;
      end
      chk("t3_done_seen", {31'b0, ok}, 1);
      chk("t3_bank_flip", wr_bank, 1);
      repeat (2) @(negedge clock);

`ifdef FDAU_SCHED_CKSUM_EN
      da = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      cks_frame(da, 1'b1, 16'h000A);
      da = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000};
      cks_frame(da, 1'b0, 16'h0001);
`endif

      // randomized traffic against the scoreboard
      do_reset();
      for (int i = 0; i < 4; i++) dv[i] = 16'h0;
      sum_m    = 16'h0;
      bank_m   = 1'b0;
      ptr_m    = 0;
      cnt_m    = 0;
      stall    = 0;
      in_frame = 1'b0;
      busy_exp = 1'b0;
      done_exp = 1'b0;
      cks_exp  = 1'b0;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         @(negedge clock);
         chk("r_busy", busy, busy_exp);
         chk("r_done", frame_done, done_exp);
         chk("r_ovr", overrun, 0);
         chk("r_rdbank", rd_bank, !wr_bank);
`ifdef FDAU_SCHED_CKSUM_EN
         chk("r_cks_slot", ram_wren && gnt == 4'b0, cks_exp);
`else
         chk("r_wren_gnt", ram_wren, gnt != 4'b0);
`endif
         if (gnt != 4'b0 || !(in_frame && cnt_m < FL && req != 4'b0)) stall = 0;
         else stall++;
         chk("r_stall", stall > 2, 0);
         done_exp = 1'b0;
         cks_exp  = 1'b0;
         if (gnt != 4'b0) begin
            ei = rr_pick(req, ptr_m);
            eg = (ei < 4) ? (4'b0001 << ei) : 4'b0000;
            chk("r_gnt_ok", in_frame && cnt_m < FL, 1);
            chk("r_gnt", gnt, eg);
            chk("r_wren", ram_wren, 1);
            chk("r_addr", ram_wraddress, {bank_m, 8'(cnt_m)});
            chk("r_data", ram_data, dv[ei % 4]);
            sum_m = sum_m + dv[ei % 4];
            cnt_m++;
            ptr_m = (ei + 1) % 4;
            if (cnt_m == FL) begin
`ifdef FDAU_SCHED_CKSUM_EN
               cks_exp = 1'b1;
`else
               done_exp = 1'b1;
`endif
            end
         end
`ifdef FDAU_SCHED_CKSUM_EN
         else if (ram_wren) begin
            chk("r_cks_addr", ram_wraddress, {bank_m, 8'(FL)});
            chk("r_cks_data", ram_data, sum_m);
            done_exp = 1'b1;
         end
`endif
         if (frame_done) begin
            bank_m = !bank_m;
            chk("r_wrbank", wr_bank, bank_m);
            in_frame = 1'b0;
         end
         sec = 1'b0;
         if (frame_done) begin
            busy_exp = 1'b0;
            if ($urandom_range(1) == 0) sec = 1'b1;
         end else if (!busy_exp && $urandom_range(2) == 0) begin
            sec = 1'b1;
         end
         if (sec) begin
            in_frame = 1'b1;
            cnt_m    = 0;
            sum_m    = 16'h0;
            busy_exp = 1'b1;
         end
         nreq = req & ~gnt;
         for (int i = 0; i < 4; i++) begin
            if (!nreq[i] && !gnt[i] && $urandom_range(2) == 0) begin
               nreq[i] = 1'b1;
               dv[i] = 16'($urandom);
               din[16*i +: 16] = dv[i];
            end
         end
         req = nreq;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
